// File: rtl/pe_cfg_sequencer_if.sv
// Upstream config-word handshake between the instruction source and the PE sequencer.
interface pe_cfg_sequencer_if #(
  parameter int NUM_PE = 4,
  parameter int INST_W = 28
) ();
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [NUM_PE*INST_W-1:0] cfg_data;

  modport master (
    output cfg_valid,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/pe_cfg_sequencer.sv
// Per-kernel PE row controller: clear, load config buffers, replay ctx_len slots, drain, done.
//
// state | meaning
// IDLE  | waiting for start; bad ctx_len pulses err
// CLR   | one-cycle pe_rst to all PEs
// LOAD  | accepting ctx_len words, each written with pe_init
// RUN   | pe_run for ctx_len consecutive cycles
// DRAIN | DRAIN_CYC cycles flushing PE pipeline
// DONE  | one-cycle done pulse
module pe_cfg_sequencer #(
  parameter int NUM_PE    = 4,
  parameter int INST_W    = 28,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = 5,
  parameter int DRAIN_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [CNT_W-1:0]         ctx_len,
  pe_cfg_sequencer_if.slave        cfg,
  output logic                     pe_rst,
  output logic                     pe_init,
  output logic                     pe_run,
  output logic [NUM_PE*INST_W-1:0] pe_inst,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {IDLE, CLR, LOAD, RUN, DRAIN, DONE} state_t;

  state_t                    state, state_nx;
  logic [CNT_W-1:0]          len_r, len_nx;
  logic [CNT_W-1:0]          ld_cnt, ld_nx;
  logic [CNT_W-1:0]          run_cnt, run_nx;
  logic [DRN_W-1:0]          drain_cnt, drain_nx;
  logic [NUM_PE*INST_W-1:0]  inst_nx;
  logic                      rst_nx, init_nx, run_o_nx, done_nx, err_nx;
  logic                      hs;

  // abort masks ready so a word offered in the abort cycle is never consumed
  assign cfg.cfg_ready = (state == LOAD) && !abort;
  assign hs            = cfg.cfg_valid && cfg.cfg_ready;

  always_comb begin
    state_nx = state;
    len_nx   = len_r;
    ld_nx    = ld_cnt;
    run_nx   = run_cnt;
    drain_nx = drain_cnt;
    inst_nx  = pe_inst;
    rst_nx   = 1'b0;
    init_nx  = 1'b0;
    run_o_nx = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    if (abort && state != IDLE && state != DONE) begin
      state_nx = IDLE;
      rst_nx   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (ctx_len == '0 || ctx_len > CNT_W'(DEPTH)) begin
              err_nx = 1'b1;
            end else begin
              len_nx   = ctx_len;
              rst_nx   = 1'b1;
              state_nx = CLR;
            end
          end
        end
        CLR: begin
          ld_nx    = '0;
          state_nx = LOAD;
        end
        LOAD: begin
          if (hs) begin
            inst_nx = cfg.cfg_data;
            init_nx = 1'b1;
            ld_nx   = ld_cnt + CNT_W'(1);
            if (ld_cnt + CNT_W'(1) == len_r) begin
              run_nx   = '0;
              state_nx = RUN;
            end
          end
        end
        RUN: begin
          if (run_cnt == len_r) begin
            drain_nx = DRN_W'(DRAIN_CYC - 1);
            state_nx = DRAIN;
          end else begin
            run_o_nx = 1'b1;
            run_nx   = run_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            done_nx  = 1'b1;
            state_nx = DONE;
          end else begin
            drain_nx = drain_cnt - DRN_W'(1);
          end
        end
        DONE: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_r     <= '0;
      ld_cnt    <= '0;
      run_cnt   <= '0;
      drain_cnt <= '0;
      pe_inst   <= '0;
      pe_rst    <= 1'b1;
      pe_init   <= 1'b0;
      pe_run    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      len_r     <= len_nx;
      ld_cnt    <= ld_nx;
      run_cnt   <= run_nx;
      drain_cnt <= drain_nx;
      pe_inst   <= inst_nx;
      pe_rst    <= rst_nx;
      pe_init   <= init_nx;
      pe_run    <= run_o_nx;
      busy      <= (state_nx != IDLE);
      done      <= done_nx;
      err       <= err_nx;
    end
  end

endmodule

// File: tb/tb_pe_cfg_sequencer.sv
// Directed bench for pe_cfg_sequencer: launch, load, replay, drain, abort and illegal-length cases.
module tb_pe_cfg_sequencer;

  localparam int NUM_PE    = 4;
  localparam int INST_W    = 28;
  localparam int DEPTH     = 16;
  localparam int CNT_W     = 5;
  localparam int DRAIN_CYC = 2;
  localparam int W         = NUM_PE * INST_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] ctx_len;
  logic             pe_rst, pe_init, pe_run, busy, done, err;
  logic [W-1:0]     pe_inst;

  pe_cfg_sequencer_if #(.NUM_PE(NUM_PE), .INST_W(INST_W)) cfg_if ();

  pe_cfg_sequencer #(
    .NUM_PE(NUM_PE), .INST_W(INST_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ctx_len(ctx_len),
    .cfg(cfg_if), .pe_rst(pe_rst), .pe_init(pe_init), .pe_run(pe_run),
    .pe_inst(pe_inst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] word(input int i);
    logic [W-1:0] w;
    w = '0;
    for (int p = 0; p < NUM_PE; p++)
      w[p*INST_W +: INST_W] = INST_W'(32'h0A50000 + 16 * i + p);
    return w;
  endfunction

  // activity monitor sampled mid-cycle
  int cyc = 0;
  int n_init = 0, n_run = 0, n_rst = 0, n_done = 0, n_err = 0, n_both = 0;
  int last_init_cyc = 0, first_run_cyc = 0, done_cyc = 0;
  logic run_prev = 1'b0;
  logic [W-1:0] q_inst[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pe_init) begin
      n_init        <= n_init + 1;
      last_init_cyc <= cyc;
      q_inst.push_back(pe_inst);
    end
    if (pe_run) n_run <= n_run + 1;
    if (pe_run && !run_prev) first_run_cyc <= cyc;
    run_prev <= pe_run;
    if (pe_rst) n_rst <= n_rst + 1;
    if (done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (err) n_err <= n_err + 1;
    if (pe_init && pe_run) n_both <= n_both + 1;
  end

  // mode 0: cfg_valid held high; mode 1: cfg_valid 1,0,0,1,...
  task automatic kernel(input int len, input int mode, input int abort_after,
                        input int mid_start, input string nm);
    int b_init, b_run, b_rst, b_done, b_err, b_both, q_base, s_cyc;
    int k, acc, abort_k, limit;
    bit aborted, chk_ready, fin;
    b_init = n_init; b_run = n_run; b_rst = n_rst; b_done = n_done;
    b_err = n_err; b_both = n_both; q_base = q_inst.size();
    k = 0; acc = 0; abort_k = 0; aborted = 0; chk_ready = 0; fin = 0;
    limit = 4 * DEPTH + 20;
    ctx_len = CNT_W'(len);
    s_cyc = cyc;
    while (!fin) begin
      start            = (k == 0) || (k == mid_start);
      abort            = (abort_after >= 0) && !aborted && (k > 0) && (acc == abort_after);
      cfg_if.cfg_valid = (mode == 0) ? 1'b1 : (k % 3 == 0);
      cfg_if.cfg_data  = word(acc);
      @(negedge clk);
      if (chk_ready) begin
        check_val({nm, " ready low after last word"}, cfg_if.cfg_ready, 0);
        chk_ready = 0;
      end
      if (abort) begin
        check_val({nm, " ready low in abort cycle"}, cfg_if.cfg_ready, 0);
        aborted = 1;
        abort_k = k;
      end
      if (cfg_if.cfg_valid && cfg_if.cfg_ready) begin
        acc++;
        if (acc == len) chk_ready = 1;
      end
      @(posedge clk);
      #1;
      k++;
      if (abort_after < 0 && n_done != b_done) fin = 1;
      if (aborted && k > abort_k + 8) fin = 1;
      if (k > limit) fin = 1;
    end
    start = 1'b0; abort = 1'b0; cfg_if.cfg_valid = 1'b0;
    check_val({nm, " finished within budget"}, (k <= limit), 1);
    check_val({nm, " init/run overlap"}, n_both - b_both, 0);
    check_val({nm, " err pulses"}, n_err - b_err, 0);
    check_val({nm, " busy after end"}, busy, 0);
    if (abort_after < 0) begin
      check_val({nm, " pe_init pulses"}, n_init - b_init, len);
      check_val({nm, " pe_run pulses"}, n_run - b_run, len);
      check_val({nm, " pe_rst pulses"}, n_rst - b_rst, 1);
      check_val({nm, " done pulses"}, n_done - b_done, 1);
      check_val({nm, " run follows init"}, first_run_cyc - last_init_cyc, 1);
      if (mode == 0)
        check_val({nm, " start-to-done latency"}, done_cyc - s_cyc, 2 * len + DRAIN_CYC + 3);
    end else begin
      check_val({nm, " pe_init pulses"}, n_init - b_init, abort_after);
      check_val({nm, " pe_run pulses"}, n_run - b_run, 0);
      check_val({nm, " pe_rst pulses"}, n_rst - b_rst, 2);
      check_val({nm, " done pulses"}, n_done - b_done, 0);
    end
    for (int i = 0; i < len && q_base + i < q_inst.size(); i++)
      check_val({nm, " loaded word"}, q_inst[q_base + i], word(i));
  endtask

  task automatic bad_start(input int len, input string nm);
    int b_rst, b_init, b_run;
    b_rst = n_rst; b_init = n_init; b_run = n_run;
    ctx_len = CNT_W'(len);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_val({nm, " err pulse"}, err, 1);
    check_val({nm, " busy"}, busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val({nm, " err one cycle"}, err, 0);
    check_val({nm, " no PE activity"}, (n_rst - b_rst) + (n_init - b_init) + (n_run - b_run), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ctx_len = '0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_data = '0;
    repeat (3) @(negedge clk);
    check_val("reset pe_rst", pe_rst, 1);
    check_val("reset pe_init", pe_init, 0);
    check_val("reset pe_run", pe_run, 0);
    check_val("reset pe_inst", pe_inst, 0);
    check_val("reset busy", busy, 0);
    check_val("reset done", done, 0);
    check_val("reset err", err, 0);
    check_val("reset cfg_ready", cfg_if.cfg_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("pe_rst released", pe_rst, 0);
    @(posedge clk); #1;

    kernel(4, 0, -1, -1, "len4 streaming");
    kernel(4, 1, -1, -1, "len4 gapped");
    bad_start(0, "ctx_len 0");
    bad_start(17, "ctx_len 17");
    kernel(4, 0, 2, -1, "abort after 2");
    kernel(2, 0, -1, -1, "len2 after abort");

    begin
      int b_done, b_rst;
      b_done = n_done; b_rst = n_rst;
      kernel(16, 0, -1, 25, "len16 restart ignored");
      repeat (6) @(posedge clk);
      #1;
      check_val("len16 single done", n_done - b_done, 1);
      check_val("len16 no relaunch", n_rst - b_rst, 1);
      check_val("len16 idle", busy, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
